// File: rtl/discrete_i2s_tx.sv
// Mono-to-stereo I2S transmitter: a sample FIFO feeds 32-slot frames, with each
// sample duplicated to both channels and a one-bit delay after each lrck edge.
module discrete_i2s_tx #(
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          I_RSTn,
    input  logic                          audio_clk_en,
    input  logic signed [15:0]            in,
    input  logic                          clear_flags,
    output logic                          sclk,
    output logic                          lrck,
    output logic                          sdata,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       slot;
    logic [31:0]      shreg;
    logic [15:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [15:0]      last_s;

    logic        tick;
    logic        fall;
    logic [4:0]  slot_nx;
    logic        load;
    logic        pop;
    logic        push_ok;
    logic [15:0] head;
    logic [15:0] frame_s;

    always_comb begin
        tick    = (div_cnt == DIV_LAST);
        fall    = tick && sclk;
        slot_nx = slot + 5'd1;
        load    = fall && (slot_nx == 5'd1);
        pop     = load && (level != '0);
        // A pop in the same cycle frees the entry the push needs, so a full FIFO still accepts.
        push_ok = audio_clk_en && ((level != LW'(FIFO_DEPTH)) || pop);
        head    = mem[rd_ptr];
        frame_s = pop ? head : last_s;
    end

    assign sdata = shreg[31];

    always_ff @(posedge clk) begin
        if (I_RSTn && push_ok)
            mem[wr_ptr] <= in;
    end

    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            div_cnt   <= '0;
            sclk      <= 1'b0;
            lrck      <= 1'b0;
            slot      <= '0;
            shreg     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            last_s    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                sclk <= ~sclk;

            if (fall) begin
                slot <= slot_nx;
                lrck <= slot_nx[4];
                if (load)
                    shreg <= {frame_s, frame_s};
                else
                    shreg <= {shreg[30:0], 1'b0};
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_s <= head;
            end
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            level <= level + LW'(push_ok) - LW'(pop);

            // A set condition wins over a same-cycle clear.
            if (audio_clk_en && !push_ok)
                overflow <= 1'b1;
            else if (clear_flags)
                overflow <= 1'b0;

            if (load && (level == '0))
                underflow <= 1'b1;
            else if (clear_flags)
                underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_discrete_i2s_tx.sv
// Self-checking bench for discrete_i2s_tx against a cycle-count based reference model.
module tb_discrete_i2s_tx;

    localparam int B = 2;
    localparam int D = 4;

    logic        clk;
    logic        I_RSTn;
    logic        audio_clk_en;
    logic [15:0] in_s;
    logic        clear_flags;
    logic        sclk, lrck, sdata, overflow, underflow;
    logic [2:0]  level;
    logic [7:0]  act;

    int total = 0;
    int bad   = 0;

    // Reference model state: edges since reset release, FIFO queue, last popped sample, frame word, flags.
    int          mt;
    logic [15:0] q[$];
    logic [15:0] mlast;
    logic [31:0] mw;
    bit          mof, muf;
    logic [31:0] cap;

    discrete_i2s_tx #(.BCLK_DIV(B), .FIFO_DEPTH(D)) dut (
        .clk(clk), .I_RSTn(I_RSTn), .audio_clk_en(audio_clk_en), .in(in_s),
        .clear_flags(clear_flags), .sclk(sclk), .lrck(lrck), .sdata(sdata),
        .level(level), .overflow(overflow), .underflow(underflow)
    );

    assign act = {sclk, lrck, sdata, overflow, underflow, level};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {sclk,lrck,sdata,overflow,underflow,level} after mt edges since release.
    function automatic logic [7:0] exp_vec();
        int k, s, idx;
        logic sc, lr, sd;
        sc  = ((mt / B) % 2) == 1;
        k   = mt / (2 * B);
        s   = k % 32;
        lr  = (s >= 16);
        idx = (s == 0) ? 0 : 32 - s;
        sd  = (k == 0) ? 1'b0 : mw[idx];
        return {sc, lr, sd, mof, muf, 3'(q.size())};
    endfunction

    task automatic step(input bit en, input logic [15:0] d, input bit clr, input bit rst);
        bit ld, ofs, ufs;
        logic [15:0] s;
        audio_clk_en = en;
        in_s         = d;
        clear_flags  = clr;
        I_RSTn       = rst;
        @(posedge clk);
        if (!rst) begin
            mt = 0; q.delete(); mlast = '0; mw = '0; mof = 0; muf = 0;
        end else begin
            mt++;
            ofs = 0; ufs = 0;
            ld = (mt % (2 * B) == 0) && ((mt / (2 * B)) % 32 == 1);
            if (ld) begin
                if (q.size() > 0) begin
                    s = q.pop_front();
                    mlast = s;
                end else begin
                    s = mlast;
                    ufs = 1;
                end
                mw = {s, s};
            end
            if (en) begin
                if (q.size() < D) q.push_back(d);
                else ofs = 1;
            end
            mof = ofs ? 1'b1 : (clr ? 1'b0 : mof);
            muf = ufs ? 1'b1 : (clr ? 1'b0 : muf);
        end
        #1;
    endtask

    task automatic test_reset();
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        total++;
        if (act !== 8'h00) begin bad++; $display("FAIL reset_state act=%b exp=%b", act, 8'h00); end
        total++;
        if (act !== exp_vec()) begin bad++; $display("FAIL reset_model act=%b exp=%b", act, exp_vec()); end
    endtask

    task automatic test_basic_frame();
        int k;
        step(0, '0, 0, 0);
        cap = '0;
        step(1, 16'h8001, 0, 1);
        for (int i = 0; i < 140; i++) begin
            step(0, '0, 0, 1);
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL basic t=%0d act=%b exp=%b", mt, act, exp_vec()); end
            k = mt / (2 * B);
            if (mt % (2 * B) == 0 && k >= 1 && k <= 32) cap[32 - k] = sdata;
        end
        total++;
        if (cap !== 32'h80018001) begin bad++; $display("FAIL basic_bits act=%h exp=%h", cap, 32'h80018001); end
        total++;
        if (level !== 3'd0) begin bad++; $display("FAIL basic_level act=%0d exp=0", level); end
    endtask

    task automatic test_underflow();
        step(0, '0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            step(0, '0, 0, 1);
            total++;
            if (sdata !== 1'b0 || act !== exp_vec()) begin
                bad++; $display("FAIL underflow_run t=%0d act=%b exp=%b", mt, act, exp_vec());
            end
        end
        total++;
        if (underflow !== 1'b1 || overflow !== 1'b0) begin
            bad++; $display("FAIL underflow_flags act=%b%b exp=01", overflow, underflow);
        end
    endtask

    task automatic test_repeat_last();
        int k;
        step(0, '0, 0, 0);
        step(1, 16'h1234, 0, 1);
        cap = '0;
        for (int i = 0; i < 3 * 128 + 8; i++) begin
            step(0, '0, 0, 1);
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL repeat t=%0d act=%b exp=%b", mt, act, exp_vec()); end
            k = mt / (2 * B);
            if (mt % (2 * B) == 0 && k >= 65 && k <= 96) cap[96 - k] = sdata;
        end
        total++;
        if (cap !== 32'h12341234) begin bad++; $display("FAIL repeat_frame3 act=%h exp=%h", cap, 32'h12341234); end
        total++;
        if (underflow !== 1'b1) begin bad++; $display("FAIL repeat_underflow act=%b exp=1", underflow); end
    endtask

    task automatic test_overflow();
        int k, s;
        step(0, '0, 0, 0);
        while (mt < 5) step(0, '0, 0, 1);
        for (int i = 1; i <= 5; i++) begin
            step(1, 16'hA000 + 16'(i), 0, 1);
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL ovf_push t=%0d act=%b exp=%b", mt, act, exp_vec()); end
        end
        total++;
        if (level !== 3'd4 || overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_state level=%0d ovf=%b exp level=4 ovf=1", level, overflow);
        end
        cap = '0;
        for (int i = 0; i < 5 * 128; i++) begin
            step(0, '0, 0, 1);
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL ovf_run t=%0d act=%b exp=%b", mt, act, exp_vec()); end
            k = mt / (2 * B);
            s = k % 32;
            if (mt % (2 * B) == 0 && k >= 33) begin
                cap[(s == 0) ? 0 : 32 - s] = sdata;
                if (s == 0) begin
                    total++;
                    if (cap[31:16] === 16'hA005 || cap[15:0] === 16'hA005) begin
                        bad++; $display("FAIL ovf_dropped_seen frame=%h must not carry a005", cap);
                    end
                end
            end
        end
    endtask

    task automatic test_full_boundary();
        int k, s;
        step(0, '0, 0, 0);
        while (mt < 5) step(0, '0, 0, 1);
        for (int i = 1; i <= 4; i++) step(1, 16'hB000 + 16'(i), 0, 1);
        step(0, '0, 1, 1);
        while (mt < 131) step(0, '0, 0, 1);
        step(1, 16'hB005, 0, 1);
        total++;
        if (level !== 3'd4 || overflow !== 1'b0) begin
            bad++; $display("FAIL full_boundary level=%0d ovf=%b exp level=4 ovf=0", level, overflow);
        end
        cap = '0;
        for (int i = 0; i < 5 * 128; i++) begin
            step(0, '0, 0, 1);
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL full_run t=%0d act=%b exp=%b", mt, act, exp_vec()); end
            k = mt / (2 * B);
            s = k % 32;
            if (mt % (2 * B) == 0 && k >= 161 && k <= 192) begin
                cap[(s == 0) ? 0 : 32 - s] = sdata;
                if (k == 192) begin
                    total++;
                    if (cap !== 32'hB005B005) begin bad++; $display("FAIL full_late_sample act=%h exp=%h", cap, 32'hB005B005); end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int first_rise, first_fall;
        step(0, '0, 0, 0);
        step(1, 16'hC0DE, 0, 1);
        step(1, 16'h7777, 0, 1);
        while (mt < 42) step(0, '0, 0, 1);
        step(0, '0, 0, 0);
        total++;
        if (act !== 8'h00) begin bad++; $display("FAIL midreset_state act=%b exp=%b", act, 8'h00); end
        first_rise = -1; first_fall = -1;
        for (int i = 1; i <= 300; i++) begin
            step(0, '0, 0, 1);
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL midreset_run t=%0d act=%b exp=%b", mt, act, exp_vec()); end
            if (first_rise < 0 && sclk === 1'b1) first_rise = i;
            if (first_rise >= 0 && first_fall < 0 && sclk === 1'b0) first_fall = i;
        end
        total++;
        if (first_rise != B || first_fall != 2 * B) begin
            bad++; $display("FAIL midreset_timing rise=%0d fall=%0d exp rise=%0d fall=%0d", first_rise, first_fall, B, 2 * B);
        end
    endtask

    task automatic test_random();
        bit en, clr, rst;
        logic [15:0] d;
        step(0, '0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom_range(0, 99) < 3);
            clr = ($urandom_range(0, 99) < 4);
            rst = ($urandom_range(0, 999) >= 2);
            d   = 16'($urandom);
            step(en, d, clr, rst);
            total++;
            if (act !== exp_vec()) begin bad++; $display("FAIL random t=%0d act=%b exp=%b", mt, act, exp_vec()); end
        end
    endtask

    initial begin
        I_RSTn = 1'b0; audio_clk_en = 1'b0; in_s = '0; clear_flags = 1'b0;
        mt = 0; mlast = '0; mw = '0; mof = 0; muf = 0; cap = '0;
        test_reset();
        test_basic_frame();
        test_underflow();
        test_repeat_last();
        test_overflow();
        test_full_boundary();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
